// File: rtl/texture_loader.sv
// ---------------------------------------------------------------------------
// texture_loader
//   Write-side companion to the texture read controller. It accepts an upload
//   command (start address and pixel count) and then a byte stream. Every four
//   bytes are packed into one RGBA word, red byte first, and each word is
//   written to the texture RAM in a single-cycle write pulse.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-low reset
//   start          one-cycle command strobe, sampled only in IDLE
//   start_addr     first word address of the texture
//   pixel_count    number of RGBA words to write
//   abort          cancel the upload in progress (RECV / WRITE)
//   byte_in        stream byte
//   byte_valid     byte_in is valid
//   byte_ready     loader accepts a byte this cycle
//   write_address  RAM write address (held while write=0)
//   write          RAM write enable, one-cycle pulse per word
//   write_data     packed word {R,G,B,A}, held while write=0
//   busy           upload in progress (RECV or WRITE)
//   done           one-cycle pulse after the last word is written
//   error          one-cycle pulse when a command is rejected
// ---------------------------------------------------------------------------
module texture_loader #(
   parameter int ADDR_W    = 17,
   parameter int RAM_DEPTH = 2600
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] pixel_count,
   input  logic              abort,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic [ADDR_W-1:0] write_address,
   output logic              write,
   output logic [31:0]       write_data,
   output logic              busy,
   output logic              done,
   output logic              error
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;        // next word address to write
   logic [ADDR_W-1:0] remain_q, remain_d;    // words still to write
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;  // address presented to the RAM
   logic [1:0]        idx_q, idx_d;          // byte position inside the word
   logic [23:0]       part_q, part_d;        // R,G,B collected so far
   logic [31:0]       wr_data_q, wr_data_d;  // word presented to the RAM
   logic              error_q, error_d;

   logic [ADDR_W:0]   end_addr;
   logic              range_bad;
   logic              xfer;

   // One extra bit so the end address cannot wrap for large commands.
   assign end_addr  = {1'b0, start_addr} + {1'b0, pixel_count};
   assign range_bad = end_addr > (ADDR_W+1)'(RAM_DEPTH);

   // byte_ready is exactly "state is RECV", so a transfer is RECV plus valid.
   // Abort wins over a byte arriving in the same cycle.
   assign xfer = (state_q == RECV) && byte_valid && !abort;

   // ------------------------------------------------------------------------
   // State register and datapath flops
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of block order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         remain_q  <= '0;
         wr_addr_q <= '0;
         idx_q     <= '0;
         part_q    <= '0;
         wr_data_q <= '0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         remain_q  <= remain_d;
         wr_addr_q <= wr_addr_d;
         idx_q     <= idx_d;
         part_q    <= part_d;
         wr_data_q <= wr_data_d;
         error_q   <= error_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (pixel_count == '0) state_d = DONE;
               else if (range_bad)    state_d = IDLE;
               else                   state_d = RECV;
            end
         end
         RECV: begin
            if (abort)                          state_d = IDLE;
            else if (xfer && (idx_q == 2'd3))   state_d = WRITE;
         end
         WRITE: begin
            if (abort)                          state_d = IDLE;
            else if (remain_q == ADDR_W'(1))    state_d = DONE;
            else                                state_d = RECV;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath next values
   // ------------------------------------------------------------------------
   always_comb begin
      addr_d    = addr_q;
      remain_d  = remain_q;
      wr_addr_d = wr_addr_q;
      idx_d     = idx_q;
      part_d    = part_q;
      wr_data_d = wr_data_q;
      error_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               addr_d   = start_addr;
               remain_d = pixel_count;
               idx_d    = 2'd0;
               error_d  = (pixel_count != '0) && range_bad;
            end
         end
         RECV: begin
            if (abort) begin
               // Drop the partial word; the next command restarts at R.
               idx_d = 2'd0;
            end else if (xfer) begin
               idx_d = idx_q + 2'd1;
               unique case (idx_q)
                  2'd0: part_d[23:16] = byte_in;
                  2'd1: part_d[15:8]  = byte_in;
                  2'd2: part_d[7:0]   = byte_in;
                  2'd3: begin
                     // Load the RAM-facing registers here so they are stable
                     // for the whole WRITE cycle and held afterwards.
                     wr_data_d = {part_q, byte_in};
                     wr_addr_d = addr_q;
                  end
                  default: ;
               endcase
            end
         end
         WRITE: begin
            idx_d = 2'd0;
            if (!abort) begin
               addr_d   = addr_q + ADDR_W'(1);
               remain_d = remain_q - ADDR_W'(1);
            end
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs: decoded from registered state, so they follow reset at once.
   // ------------------------------------------------------------------------
   always_comb begin
      byte_ready    = (state_q == RECV);
      write         = (state_q == WRITE) && !abort;
      busy          = (state_q == RECV) || (state_q == WRITE);
      done          = (state_q == DONE);
      error         = error_q;
      write_address = wr_addr_q;
      write_data    = wr_data_q;
   end

endmodule

// File: tb/tb_texture_loader.sv
// ---------------------------------------------------------------------------
// tb_texture_loader
//   Directed stimulus with a write scoreboard: the driver pushes the expected
//   {address, word} for every word it intends to have written, and a negedge
//   monitor pops and compares each time the DUT pulses write.
// ---------------------------------------------------------------------------
module tb_texture_loader;

   localparam int ADDR_W    = 17;
   localparam int RAM_DEPTH = 2600;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W-1:0] pixel_count;
   logic              abort;
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic [ADDR_W-1:0] write_address;
   logic              write;
   logic [31:0]       write_data;
   logic              busy;
   logic              done;
   logic              error;

   texture_loader #(.ADDR_W(ADDR_W), .RAM_DEPTH(RAM_DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .start_addr    (start_addr),
      .pixel_count   (pixel_count),
      .abort         (abort),
      .byte_in       (byte_in),
      .byte_valid    (byte_valid),
      .byte_ready    (byte_ready),
      .write_address (write_address),
      .write         (write),
      .write_data    (write_data),
      .busy          (busy),
      .done          (done),
      .error         (error)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   wr_t exp_q[$];
   int  wr_times[$];
   int  wr_cnt = 0, done_cnt = 0, err_cnt = 0, ready_cyc = 0, ready_viol = 0;
   int  last_done = -1;
   int  t_start = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (reset) begin
         if (byte_ready) ready_cyc++;
         if (busy && !write && !byte_ready) ready_viol++;
         if (error) err_cnt++;
         if (done) begin
            done_cnt++;
            last_done = cyc;
         end
         if (write) begin
            wr_cnt++;
            wr_times.push_back(cyc);
            if (exp_q.size() == 0) begin
               check("unexpected_write", 32'(write_address), 32'hFFFF_FFFF);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_addr", 32'(write_address), 32'(e.addr));
               check("wr_data", write_data, e.data);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cmd(input int a, input int c);
      start       = 1'b1;
      start_addr  = ADDR_W'(a);
      pixel_count = ADDR_W'(c);
      tick(1);
      start   = 1'b0;
      t_start = cyc;
   endtask

   task automatic expect_wr(input int a, input logic [31:0] d);
      wr_t e;
      e.addr = ADDR_W'(a);
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n          = 0;
      byte_in    = b;
      byte_valid = 1'b1;
      while (!byte_ready && n < 50) begin
         tick(1);
         n++;
      end
      if (!byte_ready) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
      tick(1);
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   int wr0, dn0, er0, rd0, n0;

   task automatic snap();
      wr0 = wr_cnt;
      dn0 = done_cnt;
      er0 = err_cnt;
      rd0 = ready_cyc;
      n0  = wr_times.size();
   endtask

   initial begin
      reset       = 1'b0;
      start       = 1'b0;
      start_addr  = '0;
      pixel_count = '0;
      abort       = 1'b0;
      byte_in     = '0;
      byte_valid  = 1'b0;

      // Reset state
      #3;
      check("rst_byte_ready", 32'(byte_ready), 32'd0);
      check("rst_write",      32'(write),      32'd0);
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_done",       32'(done),       32'd0);
      check("rst_error",      32'(error),      32'd0);
      check("rst_wr_addr",    32'(write_address), 32'd0);
      check("rst_wr_data",    write_data,      32'd0);
      tick(2);
      reset = 1'b1;
      tick(2);

      // Normal upload
      snap();
      expect_wr(50, 32'h1122_3344);
      expect_wr(51, 32'hAABB_CCDD);
      cmd(50, 2);
      check("norm_busy", 32'(busy), 32'd1);
      send_word(32'h1122_3344);
      send_word(32'hAABB_CCDD);
      tick(4);
      check("norm_writes", 32'(wr_cnt - wr0), 32'd2);
      check("norm_first_lat", 32'(wr_times[n0] - t_start), 32'd4);
      check("norm_spacing", 32'(wr_times[n0+1] - wr_times[n0]), 32'd5);
      check("norm_done_cnt", 32'(done_cnt - dn0), 32'd1);
      check("norm_done_time", 32'(last_done - wr_times[n0+1]), 32'd1);
      check("norm_busy_after", 32'(busy), 32'd0);

      // Stalled stream: 3 idle cycles between bytes 2 and 3
      snap();
      ready_viol = 0;
      expect_wr(50, 32'h1122_3344);
      expect_wr(51, 32'hAABB_CCDD);
      cmd(50, 2);
      send_byte(8'h11);
      send_byte(8'h22);
      tick(3);
      send_byte(8'h33);
      send_byte(8'h44);
      send_word(32'hAABB_CCDD);
      tick(4);
      check("stall_writes", 32'(wr_cnt - wr0), 32'd2);
      check("stall_first_lat", 32'(wr_times[n0] - t_start), 32'd7);
      check("stall_ready_held", 32'(ready_viol), 32'd0);
      check("stall_done_cnt", 32'(done_cnt - dn0), 32'd1);

      // Range rejection
      snap();
      cmd(RAM_DEPTH - 1, 2);
      check("rej_busy", 32'(busy), 32'd0);
      tick(3);
      check("rej_error_cycles", 32'(err_cnt - er0), 32'd1);
      check("rej_writes", 32'(wr_cnt - wr0), 32'd0);
      check("rej_done", 32'(done_cnt - dn0), 32'd0);

      // Largest legal range
      snap();
      expect_wr(RAM_DEPTH - 2, 32'h0102_0304);
      expect_wr(RAM_DEPTH - 1, 32'hF0E0_D0C0);
      cmd(RAM_DEPTH - 2, 2);
      send_word(32'h0102_0304);
      send_word(32'hF0E0_D0C0);
      tick(4);
      check("edge_writes", 32'(wr_cnt - wr0), 32'd2);
      check("edge_error", 32'(err_cnt - er0), 32'd0);
      check("edge_done", 32'(done_cnt - dn0), 32'd1);

      // Zero length
      snap();
      cmd(50, 0);
      tick(3);
      check("zero_done", 32'(done_cnt - dn0), 32'd1);
      check("zero_writes", 32'(wr_cnt - wr0), 32'd0);
      check("zero_ready", 32'(ready_cyc - rd0), 32'd0);
      check("zero_error", 32'(err_cnt - er0), 32'd0);

      // Abort after 6 bytes (one word written)
      snap();
      expect_wr(200, 32'h5152_5354);
      cmd(200, 3);
      send_word(32'h5152_5354);
      send_byte(8'h61);
      send_byte(8'h62);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ready", 32'(byte_ready), 32'd0);
      tick(3);
      check("abort_writes", 32'(wr_cnt - wr0), 32'd1);
      check("abort_done", 32'(done_cnt - dn0), 32'd0);
      check("abort_error", 32'(err_cnt - er0), 32'd0);

      // Fresh command after abort: packing restarts at R
      snap();
      expect_wr(100, 32'h7172_7374);
      cmd(100, 1);
      send_word(32'h7172_7374);
      tick(4);
      check("post_abort_writes", 32'(wr_cnt - wr0), 32'd1);
      check("post_abort_done", 32'(done_cnt - dn0), 32'd1);

      // Async reset mid-word
      cmd(300, 1);
      send_byte(8'h81);
      send_byte(8'h82);
      #2;
      reset = 1'b0;
      #1;
      check("areset_ready", 32'(byte_ready), 32'd0);
      check("areset_busy",  32'(busy),       32'd0);
      check("areset_addr",  32'(write_address), 32'd0);
      check("areset_data",  write_data,      32'd0);
      tick(2);
      reset = 1'b1;
      tick(1);

      snap();
      expect_wr(400, 32'h0A0B_0C0D);
      cmd(400, 1);
      send_word(32'h0A0B_0C0D);
      tick(4);
      check("post_reset_writes", 32'(wr_cnt - wr0), 32'd1);
      check("post_reset_done", 32'(done_cnt - dn0), 32'd1);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/texture_loader.md
Name: texture_loader

Overview:
- Write-side companion to the texture read controller. It accepts a texture upload command (start address, pixel count) and a byte stream from the input controller.
- It packs every 4 bytes into one RGBA word, with red as the first byte, and drives the texture RAM write port (write_address/write/write_data) one word per pixel.
- It reports busy, done and error back to the input controller.

Parameters:
- ADDR_W, 17, texture RAM address width (words)
- RAM_DEPTH, 2600, number of valid RAM words; legal addresses are 0..RAM_DEPTH-1

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle command strobe; sampled only in IDLE
- start_addr  input  ADDR_W  first word address of the texture
- pixel_count  input  ADDR_W  number of RGBA words to write
- abort  input  1  cancel the upload in progress
- byte_in  input  8  stream byte
- byte_valid  input  1  byte_in is valid
- byte_ready  output  1  loader accepts a byte this cycle
- write_address  output  ADDR_W  RAM write address
- write  output  1  RAM write enable, one-cycle pulse per word
- write_data  output  32  packed word {R,G,B,A}: R in [31:24], A in [7:0]
- busy  output  1  upload in progress
- done  output  1  one-cycle pulse when the last word is written
- error  output  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs are 0: byte_ready, write, write_address, write_data, busy, done, error. Internal byte index, word count and address are also 0.
- State machine has four states: IDLE, RECV, WRITE, DONE.
- IDLE:
  - On start=1, latch start_addr and pixel_count.
  - If pixel_count==0: go to DONE. No write occurs.
  - Else if start_addr+pixel_count > RAM_DEPTH (computed at ADDR_W+1 bits, so it cannot wrap): error=1 for the next cycle and stay in IDLE.
  - Otherwise: go to RECV with byte index=0 and remaining=pixel_count.
- RECV:
  - byte_ready=1 and busy=1.
  - A byte transfers on a cycle where byte_valid=1 and byte_ready=1.
  - Byte index 0 fills bits [31:24], 1 fills [23:16], 2 fills [15:8], 3 fills [7:0].
  - On the 4th byte, go to WRITE. byte_ready is registered, so it is 0 in the WRITE cycle.
- WRITE (exactly 1 cycle):
  - write=1, with write_address = current address and write_data = the packed word.
  - byte_ready=0 and busy=1.
  - Next: address+1, remaining-1, byte index=0.
  - If remaining was 1, go to DONE; else go back to RECV.
- DONE (1 cycle): done=1, busy=0. Then go to IDLE.
- Throughput: one word per 5 cycles at most (4 byte cycles plus 1 write cycle). Bubbles on byte_valid simply stall RECV.
- write_address and write_data hold their last values when write=0. The RAM ignores them in that case.
- abort=1 in RECV or WRITE:
  - Abort takes priority over a simultaneous byte transfer or write.
  - The loader goes to IDLE next cycle with no done and no error.
  - Any partial word is discarded. Words already written remain in RAM.
- start while not in IDLE is ignored. In IDLE, start and abort together: start wins.
- Address never exceeds RAM_DEPTH-1, guaranteed by the start check. No wrap-around logic is required.
- Reset asserted mid-upload returns to IDLE immediately. Outputs go to their reset values and the partial word is lost.

Test Plan:
- Normal upload:
  - Stimulus: reset, then start with start_addr=50, pixel_count=2; bytes 0x11,0x22,0x33,0x44,0xAA,0xBB,0xCC,0xDD streamed with no gaps.
  - Required: write@50=0x11223344, then write@51=0xAABBCCDD, 5 cycles apart. done pulses 1 cycle after the second write. busy is 0 afterwards.
- Stalled stream:
  - Stimulus: same command, with byte_valid low for 3 cycles between bytes 2 and 3.
  - Required: identical data and addresses. The first write lands 3 cycles later. byte_ready stays 1 throughout RECV.
- Range rejection:
  - Stimulus: start_addr=2599, pixel_count=2.
  - Required: error pulses 1 cycle, no write, busy=0.
  - Stimulus: start_addr=2598, pixel_count=2.
  - Required: accepted, writes to 2598 and 2599.
- Zero length:
  - Stimulus: pixel_count=0.
  - Required: done pulses 1 cycle, write never asserted, byte_ready never asserted.
- Abort:
  - Stimulus: pixel_count=3; abort after 6 bytes (1 word written).
  - Required: exactly one write, no done, IDLE next cycle.
  - Stimulus: a new start with start_addr=100, pixel_count=1.
  - Required: write@100 with the fresh 4 bytes; no leftover bytes from the aborted word.
- Async reset mid-word:
  - Stimulus: drop reset after 2 bytes.
  - Required: all outputs go to 0 immediately, without waiting for a clock edge.
  - Stimulus: after release, a new command.
  - Required: packing starts at byte index 0 (bits [31:24]).
